mult_share_arbiter: RTL and testbench

//  Shares one combinational_mult (4x4 -> 8-bit unsigned) between two requesters.
//  - Round-robin arbitration; only the granted requester's operands are captured.
//  - Operands are held stable for a configurable settle time, then the product is registered.
//  - Completion is signalled to the owner. Sits between the two client FSMs and the shared multiplier.
//

---
 rtl/mult_share_arbiter_pkg.sv | 12 +
 rtl/mult_share_arbiter_mult.sv | 32 +++
 rtl/mult_share_arbiter.sv | 134 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: FSM state
// encodings and datapath widths.
package mult_share_arbiter_pkg;

   localparam int OP_W  = 4;
   localparam int RES_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// Bit-level 4x4 -> 8 unsigned combinational multiplier shared by both requesters.
module combinational_mult (
   input  logic A3,
   input  logic A2,
   input  logic A1,
   input  logic A0,
   input  logic B3,
   input  logic B2,
   input  logic B1,
   input  logic B0,
   output logic S7,
   output logic S6,
   output logic S5,
   output logic S4,
   output logic S3,
   output logic S2,
   output logic S1,
   output logic S0
);

   logic [7:0] a_ext;
   logic [7:0] b_ext;
   logic [7:0] prod;

   // Zero-extend first so the full 8-bit product is kept.
   assign a_ext = {4'b0000, A3, A2, A1, A0};
   assign b_ext = {4'b0000, B3, B2, B1, B0};
   assign prod  = a_ext * b_ext;

   assign {S7, S6, S5, S4, S3, S2, S1, S0} = prod;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin owner of one shared combinational multiplier: latches the winner's
// operands, holds them CALC_CYCLES cycles, then registers the product and pulses done.
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int RR_INIT     = 0,
   parameter int CALC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [OP_W-1:0]  a0,
   input  logic [OP_W-1:0]  b0,
   input  logic             req1,
   input  logic [OP_W-1:0]  a1,
   input  logic [OP_W-1:0]  b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [RES_W-1:0] result,
   output logic             busy,
   output logic [1:0]       dbg_state_o
);

   localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);
   localparam logic       PTR_INIT = 1'(RR_INIT);

   logic [1:0]       state_q, state_d;
   logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic             busy_q, busy_d;
   logic [RES_W-1:0] result_q, result_d;
   logic [RES_W-1:0] prod;
   logic             win;

   combinational_mult u_mult (
      .A3(a_q[3]), .A2(a_q[2]), .A1(a_q[1]), .A0(a_q[0]),
      .B3(b_q[3]), .B2(b_q[2]), .B1(b_q[1]), .B0(b_q[0]),
      .S7(prod[7]), .S6(prod[6]), .S5(prod[5]), .S4(prod[4]),
      .S3(prod[3]), .S2(prod[2]), .S1(prod[1]), .S0(prod[0])
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      gnt0_d   = gnt0_q;
      gnt1_d   = gnt1_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      result_d = result_q;
      win      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               // Contention goes to the pointer; otherwise whoever is asking.
               win     = (req0 && req1) ? ptr_q : !req0;
               a_d     = win ? a1 : a0;
               b_d     = win ? b1 : b0;
               owner_d = win;
               gnt0_d  = !win;
               gnt1_d  = win;
               cnt_d   = CNT_INIT;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               result_d = prod;
               done0_d  = !owner_q;
               done1_d  = owner_q;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            ptr_d   = !owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         ptr_q    <= PTR_INIT;
         owner_q  <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
         result_q <= result_d;
      end
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign result      = result_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench: one instance with CALC_CYCLES=1/RR_INIT=0, one with CALC_CYCLES=4/RR_INIT=1.
module tb_mult_share_arbiter;

   logic       clk = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;

   // Instance u1: CALC_CYCLES=1, RR_INIT=0
   logic       rst, req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, done0, done1, busy;
   logic [7:0] result;
   logic [1:0] dbg_state;

   // Instance u4: CALC_CYCLES=4, RR_INIT=1
   logic       rst4, req0_4, req1_4;
   logic [3:0] a0_4, b0_4, a1_4, b1_4;
   logic       gnt0_4, gnt1_4, done0_4, done1_4, busy_4;
   logic [7:0] result_4;
   logic [1:0] dbg_state_4;

   always #5 clk = ~clk;

   mult_share_arbiter #(.RR_INIT(0), .CALC_CYCLES(1)) u1 (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .busy(busy), .dbg_state_o(dbg_state)
   );

   mult_share_arbiter #(.RR_INIT(1), .CALC_CYCLES(4)) u4 (
      .clk(clk), .rst(rst4),
      .req0(req0_4), .a0(a0_4), .b0(b0_4),
      .req1(req1_4), .a1(a1_4), .b1(b1_4),
      .gnt0(gnt0_4), .gnt1(gnt1_4), .done0(done0_4), .done1(done1_4),
      .result(result_4), .busy(busy_4), .dbg_state_o(dbg_state_4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_p;

      rst = 1'b1; rst4 = 1'b1;
      req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      req0_4 = 0; req1_4 = 0; a0_4 = 0; b0_4 = 0; a1_4 = 0; b1_4 = 0;
      step(); step();
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_done", {done0, done1}, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result, 8'h00);
      check("rst4_result", result_4, 8'h00);
      rst = 1'b0; rst4 = 1'b0;
      step();
      check("idle_busy", busy, 0);

      // 1: req0 alone, 15x15
      req0 = 1; a0 = 4'hF; b0 = 4'hF;
      step();
      check("t1_gnt0", gnt0, 1);
      check("t1_busy", busy, 1);
      check("t1_done0_early", done0, 0);
      step();
      check("t1_done0", done0, 1);
      check("t1_result", result, 8'hE1);
      check("t1_gnt0_held", gnt0, 1);
      req0 = 0;
      step();
      check("t1_done0_clear", done0, 0);
      check("t1_gnt0_clear", gnt0, 0);
      check("t1_busy_clear", busy, 0);
      check("t1_result_hold", result, 8'hE1);

      // 2: fresh reset, simultaneous requests -> requester 0 first
      rst = 1'b1; step(); rst = 1'b0;
      req0 = 1; a0 = 4'd3; b0 = 4'd5;
      req1 = 1; a1 = 4'd7; b1 = 4'd9;
      step();
      check("t2_gnt0", gnt0, 1);
      check("t2_gnt1", gnt1, 0);
      step();
      check("t2_done0", done0, 1);
      check("t2_done1_low", done1, 0);
      check("t2_result0", result, 8'h0F);
      req0 = 0;
      step();
      check("t2_resp_clear", {gnt0, gnt1, done0, done1}, 0);
      step();
      check("t2_gnt1", gnt1, 1);
      step();
      check("t2_done1", done1, 1);
      check("t2_result1", result, 8'h3F);
      req1 = 0;
      step();
      check("t2_idle", busy, 0);

      // 3: both held continuously -> 0,1,0,1; pointer is 0 here
      req0 = 1; a0 = 4'd2; b0 = 4'd3;
      req1 = 1; a1 = 4'd4; b1 = 4'd5;
      for (int k = 0; k < 4; k++) begin
         step();
         check("t3_gnt0", gnt0, (k % 2 == 0));
         check("t3_gnt1", gnt1, (k % 2 == 1));
         step();
         check("t3_done0", done0, (k % 2 == 0));
         check("t3_done1", done1, (k % 2 == 1));
         check("t3_result", result, (k % 2 == 0) ? 8'h06 : 8'h14);
         check("t3_excl", gnt0 & gnt1, 0);
         step();
         check("t3_resp", {done0, done1, gnt0, gnt1}, 0);
      end
      req0 = 0; req1 = 0;
      step();

      // 4: serve req0 so pointer favours 1, then reset during requester 1's CALC
      req0 = 1; a0 = 4'd1; b0 = 4'd1;
      step(); step(); step();
      req1 = 1; a1 = 4'd8; b1 = 4'd8;
      a0 = 4'd6; b0 = 4'd7;
      step();
      check("t4_gnt1_ptr", gnt1, 1);
      check("t4_gnt0_ptr", gnt0, 0);
      rst = 1'b1;
      #1;
      check("t4_async_gnt", {gnt0, gnt1}, 0);
      check("t4_async_done", {done0, done1}, 0);
      check("t4_async_busy", busy, 0);
      check("t4_async_result", result, 8'h00);
      step();
      check("t4_held_done", {done0, done1}, 0);
      rst = 1'b0;
      step();
      check("t4_regrant_gnt0", gnt0, 1);
      check("t4_regrant_gnt1", gnt1, 0);
      step();
      check("t4_done0", done0, 1);
      check("t4_result", result, 8'h2A);
      req0 = 0; req1 = 0;
      step();

      // 5: req1 alone; operands change and req drops after grant
      req1 = 1; a1 = 4'hC; b1 = 4'hD;
      step();
      check("t5_gnt1", gnt1, 1);
      a1 = 4'h1; b1 = 4'h1; req1 = 0;
      step();
      check("t5_done1", done1, 1);
      check("t5_result", result, 8'h9C);
      step();
      check("t5_clear", {gnt1, done1}, 0);
      step();
      check("t5_idle", {gnt1, busy}, 0);

      // RR_INIT=1 on u4: simultaneous requests favour requester 1
      req0_4 = 1; a0_4 = 4'd1; b0_4 = 4'd2;
      req1_4 = 1; a1_4 = 4'd3; b1_4 = 4'd3;
      step();
      check("rr1_gnt1", gnt1_4, 1);
      check("rr1_gnt0", gnt0_4, 0);
      req0_4 = 0;
      step(); step(); step();
      check("rr1_not_yet", done1_4, 0);
      step();
      check("rr1_done1", done1_4, 1);
      check("rr1_result", result_4, 8'h09);
      req1_4 = 0;
      step();

      // 6: CALC_CYCLES=4 exhaustive sweep on requester 1
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            exp_p = 8'(a * b);
            req1_4 = 1; a1_4 = 4'(a); b1_4 = 4'(b);
            step();
            check("t6_gnt1", gnt1_4, 1);
            for (int w = 0; w < 3; w++) begin
               step();
               check("t6_done_early", done1_4, 0);
            end
            step();
            check("t6_done1", done1_4, 1);
            check("t6_result", result_4, exp_p);
            req1_4 = 0;
            step();
            check("t6_done_clear", done1_4, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
